// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer: state encoding,
// opcode values, datapath select encodings and the control bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_RTWB   = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BEQ    = 4'd10,
      S_JMP    = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUSRCB_REGB = 2'b00;
   localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       pc_en;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       regwrite;
      logic       regdest;
      logic       memtoreg;
   } ctrl_t;

   // True on the edge that completes an instruction; a stalled store has not completed.
   function automatic logic retires(input state_t s, input logic mem_ready);
      logic r;
      r = 1'b0;
      case (s)
         S_MEMWB, S_RTWB, S_ADDIWB, S_BEQ, S_JMP: r = 1'b1;
         S_MEMWR:                                 r = mem_ready;
         default:                                 r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_control_outdec.sv
// Combinational decode of the current phase into datapath enables and mux selects.
// Only FETCH and BEQ look at the handshake/flag inputs.
module mc_outdec
   import mc_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   alu_zero,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.memread = 1'b1;
            ctrl.alusrcb = ALUSRCB_ONE;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.pcsrc   = PCSRC_ALU;
            ctrl.irwrite = mem_ready;
            ctrl.pc_en   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alusrcb = ALUSRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.memwrite = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_RTEXE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_REGB;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdest  = 1'b1;
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_BEQ: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_REGB;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.pc_en   = alu_zero;
         end
         S_JMP: begin
            ctrl.pc_en = 1'b1;
            ctrl.pcsrc = PCSRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle control sequencer: registered phase, next-phase logic, retired
// instruction counter and sticky halt flag; datapath controls come from mc_outdec.
module mc_control
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        memread,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pc_en,
   output logic [1:0]  pcsrc,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  aluop,
   output logic        regwrite,
   output logic        regdest,
   output logic        memtoreg,
   output logic        halted,
   output logic [31:0] retired,
   output logic [3:0]  state_dbg
);

   state_t      state_q, state_d;
   logic        is_store_q, is_store_d;
   logic        halted_q, halted_d;
   logic [31:0] retired_q, retired_d;
   ctrl_t       ctrl;

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      halted_d   = halted_q;
      retired_d  = retired_q;
      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            // The opcode is only trusted here, so remember lw vs sw for MEMADR.
            is_store_d = (opcode == OP_SW);
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEXE;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JMP;
               default: begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_RTEXE:  state_d = S_RTWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_RTWB, S_ADDIWB, S_BEQ, S_JMP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
      if (retires(state_q, mem_ready)) retired_d = retired_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         is_store_q <= 1'b0;
         halted_q   <= 1'b0;
         retired_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         halted_q   <= halted_d;
         retired_q  <= retired_d;
      end
   end

   mc_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .alu_zero  (alu_zero),
      .ctrl      (ctrl)
   );

   assign memread   = ctrl.memread;
   assign memwrite  = ctrl.memwrite;
   assign iord      = ctrl.iord;
   assign irwrite   = ctrl.irwrite;
   assign pc_en     = ctrl.pc_en;
   assign pcsrc     = ctrl.pcsrc;
   assign alusrca   = ctrl.alusrca;
   assign alusrcb   = ctrl.alusrcb;
   assign aluop     = ctrl.aluop;
   assign regwrite  = ctrl.regwrite;
   assign regdest   = ctrl.regdest;
   assign memtoreg  = ctrl.memtoreg;
   assign halted    = halted_q;
   assign retired   = retired_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction phase sequences with random stalls, each
// cycle checked against the phase/control table; retired counted per instruction.
module tb_mc_control;
   import mc_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic        alu_zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        memread, memwrite, iord, irwrite, pc_en, alusrca;
   logic        regwrite, regdest, memtoreg, halted;
   logic [1:0]  pcsrc, alusrcb, aluop;
   logic [31:0] retired;
   logic [3:0]  state_dbg;
   logic [14:0] obs_ctrl;

   int          total = 0;
   int          bad = 0;
   int          irw_cnt = 0;
   logic [31:0] exp_retired = 32'd0;

   logic [5:0]  legal_ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

   always #5 clk = ~clk;

   mc_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite), .iord(iord),
      .irwrite(irwrite), .pc_en(pc_en), .pcsrc(pcsrc), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .regwrite(regwrite), .regdest(regdest),
      .memtoreg(memtoreg), .halted(halted), .retired(retired), .state_dbg(state_dbg)
   );

   assign obs_ctrl = {memread, memwrite, iord, irwrite, pc_en, pcsrc, alusrca,
                      alusrcb, aluop, regwrite, regdest, memtoreg};

   // Control table straight from the phase descriptions; anything unlisted is 0.
   function automatic logic [14:0] exp_ctrl(input state_t s, input logic mr, input logic z);
      logic rd, wr, ad, irw, pce, asa, rw, rdst, m2r;
      logic [1:0] psrc, asb, aop;
      {rd, wr, ad, irw, pce, asa, rw, rdst, m2r} = '0;
      psrc = 2'b00; asb = 2'b00; aop = 2'b00;
      case (s)
         S_FETCH:  begin rd = 1; asb = 2'b01; irw = mr; pce = mr; end
         S_DECODE: asb = 2'b10;
         S_MEMADR: begin asa = 1; asb = 2'b10; end
         S_MEMRD:  begin rd = 1; ad = 1; end
         S_MEMWB:  begin rw = 1; m2r = 1; end
         S_MEMWR:  begin wr = 1; ad = 1; end
         S_RTEXE:  begin asa = 1; aop = 2'b10; end
         S_RTWB:   begin rw = 1; rdst = 1; end
         S_ADDIEX: begin asa = 1; asb = 2'b10; end
         S_ADDIWB: rw = 1;
         S_BEQ:    begin asa = 1; aop = 2'b01; psrc = 2'b01; pce = z; end
         S_JMP:    begin pce = 1; psrc = 2'b10; end
         default:  ;
      endcase
      return {rd, wr, ad, irw, pce, psrc, asa, asb, aop, rw, rdst, m2r};
   endfunction

   task automatic drive_phase(input state_t s, input logic mr, input logic [5:0] op, input logic z);
      @(negedge clk);
      mem_ready = mr;
      opcode    = (s == S_DECODE) ? op : 6'($urandom_range(0, 63));
      alu_zero  = (s == S_BEQ) ? z : 1'($urandom_range(0, 1));
      #1;
      total++;
      if (state_dbg !== 4'(s)) begin
         bad++;
         $display("FAIL state: got %0d want %0d", state_dbg, s);
      end
      total++;
      if (obs_ctrl !== exp_ctrl(s, mr, alu_zero)) begin
         bad++;
         $display("FAIL ctrl(state %0d): got %b want %b", s, obs_ctrl, exp_ctrl(s, mr, alu_zero));
      end
      total++;
      if (halted !== (s == S_HALT)) begin
         bad++;
         $display("FAIL halted(state %0d): got %b want %b", s, halted, (s == S_HALT));
      end
      if (irwrite === 1'b1) irw_cnt++;
   endtask

   task automatic check_retired(input string name);
      total++;
      if (retired !== exp_retired) begin
         bad++;
         $display("FAIL %s retired: got %h want %h", name, retired, exp_retired);
      end
   endtask

   // One legal instruction with fs fetch stalls and ms data stalls, then one idle FETCH cycle.
   task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input logic z);
      state_t exp_q[$];
      logic   mr_q[$];
      check_retired("pre");
      for (int i = 0; i < fs; i++) begin exp_q.push_back(S_FETCH); mr_q.push_back(1'b0); end
      exp_q.push_back(S_FETCH);  mr_q.push_back(1'b1);
      exp_q.push_back(S_DECODE); mr_q.push_back(1'($urandom_range(0, 1)));
      case (op)
         OP_LW, OP_SW: begin
            exp_q.push_back(S_MEMADR); mr_q.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < ms; i++) begin
               exp_q.push_back(op == OP_LW ? S_MEMRD : S_MEMWR); mr_q.push_back(1'b0);
            end
            exp_q.push_back(op == OP_LW ? S_MEMRD : S_MEMWR); mr_q.push_back(1'b1);
            if (op == OP_LW) begin exp_q.push_back(S_MEMWB); mr_q.push_back(1'($urandom_range(0, 1))); end
         end
         OP_RTYPE: begin
            exp_q.push_back(S_RTEXE); mr_q.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back(S_RTWB);  mr_q.push_back(1'($urandom_range(0, 1)));
         end
         OP_ADDI: begin
            exp_q.push_back(S_ADDIEX); mr_q.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back(S_ADDIWB); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         OP_BEQ:  begin exp_q.push_back(S_BEQ); mr_q.push_back(1'($urandom_range(0, 1))); end
         default: begin exp_q.push_back(S_JMP); mr_q.push_back(1'($urandom_range(0, 1))); end
      endcase
      irw_cnt = 0;
      while (exp_q.size() > 0) drive_phase(exp_q.pop_front(), mr_q.pop_front(), op, z);
      exp_retired = exp_retired + 32'd1;
      drive_phase(S_FETCH, 1'b0, op, z);
      check_retired("post");
      total++;
      if (irw_cnt !== 1) begin
         bad++;
         $display("FAIL irwrite_pulses op %h: got %0d want 1", op, irw_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (state_dbg !== 4'(S_FETCH) || memread !== 1'b1 || halted !== 1'b0 || retired !== 32'd0) begin
         bad++;
         $display("FAIL reset: state=%0d memread=%b halted=%b retired=%h want 0/1/0/0",
                  state_dbg, memread, halted, retired);
      end
      exp_retired = 32'd0;
   endtask

   task automatic test_addi();
      run_instr(OP_ADDI, 0, 0, 1'b0);
   endtask

   task automatic test_lw_stall();
      run_instr(OP_LW, 3, 2, 1'b0);
   endtask

   task automatic test_beq();
      run_instr(OP_BEQ, 0, 0, 1'b1);
      run_instr(OP_BEQ, 0, 0, 1'b0);
   endtask

   task automatic test_each_kind();
      run_instr(OP_SW, 0, 0, 1'b0);
      run_instr(OP_RTYPE, 1, 0, 1'b0);
      run_instr(OP_J, 0, 0, 1'b0);
      run_instr(OP_SW, 2, 3, 1'b1);
      run_instr(OP_LW, 0, 0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++)
         run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_halt();
      drive_phase(S_FETCH, 1'b1, 6'h3F, 1'b0);
      drive_phase(S_DECODE, 1'($urandom_range(0, 1)), 6'h3F, 1'b0);
      for (int i = 0; i < 20; i++)
         drive_phase(S_HALT, 1'($urandom_range(0, 1)), 6'h3F, 1'($urandom_range(0, 1)));
      check_retired("halt");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      exp_retired = 32'd0;
      total++;
      if (state_dbg !== 4'(S_FETCH) || halted !== 1'b0) begin
         bad++;
         $display("FAIL halt_reset: state=%0d halted=%b want 0/0", state_dbg, halted);
      end
      check_retired("halt_reset");
   endtask

   task automatic test_reset_in_memwr();
      drive_phase(S_FETCH, 1'b1, OP_SW, 1'b0);
      drive_phase(S_DECODE, 1'b1, OP_SW, 1'b0);
      drive_phase(S_MEMADR, 1'b1, OP_SW, 1'b0);
      drive_phase(S_MEMWR, 1'b0, OP_SW, 1'b0);
      drive_phase(S_MEMWR, 1'b0, OP_SW, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      exp_retired = 32'd0;
      total++;
      if (state_dbg !== 4'(S_FETCH) || memwrite !== 1'b0) begin
         bad++;
         $display("FAIL memwr_reset: state=%0d memwrite=%b want 0/0", state_dbg, memwrite);
      end
      check_retired("memwr_reset");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      mem_ready = 1'b0;
      force dut.retired_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.retired_q;
      exp_retired = 32'hFFFF_FFFF;
      run_instr(OP_J, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_stall();
      test_beq();
      test_halt();
      test_each_kind();
      test_reset_in_memwr();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control sequencer for the MIPS core. It replaces the single-cycle control path so that instruction fetch and data access can share one memory port, and the ALU can be reused across PC increment, address and branch computation. It tracks the instruction phase in a registered state machine, drives every datapath enable and mux select, stalls on a memory-ready handshake, and counts retired instructions.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- opcode  input  6  instruction[31:26] from the instruction register; sampled in DECODE.
- alu_zero  input  1  ALU zero flag; used in BEQ.
- mem_ready  input  1  memory has completed the current access (read data valid / write accepted) this cycle.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  output  1  load instruction register.
- pc_en  output  1  load PC.
- pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- alusrca  output  1  A operand: 0 = PC, 1 = register A.
- alusrcb  output  2  B operand: 00 register B, 01 constant 1 (word-addressed PC), 10 sign-extended immediate.
- aluop  output  2  00 add, 01 sub, 10 decode from funct.
- regwrite  output  1  register file write enable.
- regdest  output  1  destination: 0 = rt, 1 = rd.
- memtoreg  output  1  write data: 0 = ALUOut, 1 = memory data register.
- halted  output  1  sticky; illegal opcode seen.
- retired  output  32  retired-instruction count.
- state_dbg  output  4  current state encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ADDIEX, ADDIWB, BEQ, JMP, HALT.
- Opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02. Any other opcode is illegal.
- FETCH:
  - Drives memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pc_en equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE:
  - Drives alusrca=0, alusrcb=10, aluop=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw→MEMADR, R→RTEXE, addi→ADDIEX, beq→BEQ, j→JMP, illegal→HALT.
- MEMADR:
  - Drives alusrca=1, alusrcb=10, aluop=00.
  - Goes to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Drives memread=1, iord=1.
  - Waits for mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, regdest=0, memtoreg=1; then FETCH.
- MEMWR:
  - Drives memwrite=1, iord=1.
  - Waits for mem_ready, then goes to FETCH.
- RTEXE: alusrca=1, alusrcb=00, aluop=10; then RTWB.
- RTWB: regwrite=1, regdest=1, memtoreg=0; then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00; then ADDIWB.
- ADDIWB: regwrite=1, regdest=0, memtoreg=0; then FETCH.
- BEQ:
  - Drives alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pc_en=alu_zero.
  - Goes to FETCH.
- JMP: pc_en=1, pcsrc=10; then FETCH.
- HALT:
  - Absorbing state; only reset leaves it.
  - All enables 0; halted=1.
- Default output values: any output not listed for a state is 0. memread and memwrite are never both 1.
- retired counter:
  - Increments by 1 on the clock edge that leaves MEMWB, MEMWR (with mem_ready=1), RTWB, ADDIWB, BEQ or JMP.
  - Unsigned; wraps 0xFFFFFFFF→0.
  - An illegal instruction is not counted.

## Timing
- Moore state machine with a registered state. Outputs are combinational from the state, except irwrite/pc_en in FETCH (gated by mem_ready) and pc_en in BEQ (gated by alu_zero).
- Cycle counts with mem_ready held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Request outputs stay asserted and stable while stalled.
- Reset:
  - State→FETCH, retired→0, halted→0.
  - Takes effect on the next edge from any state, mid-stall included; an in-flight access is abandoned.
  - In the first cycle after reset: state_dbg=FETCH, memread=1.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Structure
- Package mc_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - encodings for aluop, alusrcb and pcsrc.
- One sub-module is natural: mc_outdec, purely combinational, mapping state, mem_ready and alu_zero to the datapath controls.
- mc_control holds the state register, the next-state logic, the retired counter and the halted flag.

## Test plan
- Reset, then addi (0x08), mem_ready=1:
  - state_dbg goes FETCH→DECODE→ADDIEX→ADDIWB→FETCH.
  - regwrite=1 with regdest=0 only in ADDIWB.
  - retired=1.
- lw with mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMRD:
  - Completes in 10 cycles.
  - memread held at 1 throughout each stall.
  - irwrite pulses exactly once.
- beq with alu_zero=1, then with alu_zero=0:
  - pc_en=1 and pcsrc=01 in the first BEQ; pc_en=0 in the second.
  - retired increments in both cases.
- Illegal opcode 0x3F:
  - DECODE→HALT; halted=1 and every enable stays 0 for 20 cycles.
  - retired unchanged.
  - reset returns state_dbg to FETCH with halted=0.
- Reset asserted during a MEMWR stall: next cycle state_dbg=FETCH, memwrite=0, retired=0.
- Preload the retired counter near wrap (force to 0xFFFFFFFF), then retire one j: retired=0x00000000.
